// File: rtl/load_use_hazard_ctrl.sv
// load_use_hazard_ctrl
//
// Load-use hazard controller that sits beside the decode stage of the
// in-order pipeline. It keeps a shadow record of the destination registers
// in flight (index 0 = EX, index i = MEMi). It freezes fetch/decode while a
// decode source operand depends on a result that cannot be forwarded yet.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   dec_valid       decode holds a valid instruction
//   rs1_dec/rs2_dec decode source registers, qualified by rs1_used/rs2_used
//   rd_dec          decode destination, written when rd_wen_dec is set
//   is_load_dec     decode instruction is a load
//   flush           kill the decode instruction (redirect); beats stall
//   hold            global freeze; the tracker and stall_run do not advance
//   clr_cnt         clear stall_total (wins over an increment)
//   stall           combinational: freeze PC and IF/ID, bubble into EX
//   bubble_ins      registered: a bubble entered EX on the last edge
//   stall_run       consecutive stall cycles, saturating
//   stall_total     total stall cycles, saturating
//   err             sticky watchdog flag, set when stall_run hits MAX_STALL
module load_use_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MEM_STAGES = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16,
  parameter int RUN_W      = 3,
  parameter int MAX_STALL  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] rs1_dec,
  input  logic [REG_AW-1:0] rs2_dec,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd_dec,
  input  logic              rd_wen_dec,
  input  logic              is_load_dec,
  input  logic              flush,
  input  logic              hold,
  input  logic              clr_cnt,
  output logic              stall,
  output logic              bubble_ins,
  output logic [RUN_W-1:0]  stall_run,
  output logic [CNT_W-1:0]  stall_total,
  output logic              err
);

  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Tracker: one entry per downstream stage, index 0 = EX.
  logic [MEM_STAGES-1:0] trk_v;
  logic [MEM_STAGES-1:0] trk_ld;
  logic [REG_AW-1:0]     trk_rd [MEM_STAGES];

  logic [MEM_STAGES-1:0] hit;
  logic                  hazard;
  logic                  wr0;

  // Decode-stage compare against every tracked writer.
  always_comb begin
    hit = '0;
    for (int i = 0; i < MEM_STAGES; i++) begin
      // x0 never carries a dependency; with forwarding only loads are late.
      if (trk_v[i] && (trk_rd[i] != '0) && (trk_ld[i] || (FWD_EN == 0)) &&
          ((rs1_used && (rs1_dec == trk_rd[i])) ||
           (rs2_used && (rs2_dec == trk_rd[i])))) begin
        hit[i] = 1'b1;
      end
    end
  end

  assign hazard = dec_valid & (|hit);
  // Flush wins: a killed instruction has no operands to wait for.
  assign stall  = hazard & ~flush & ~reset;
  // Only an instruction actually leaving decode becomes a tracked writer.
  assign wr0    = dec_valid & ~stall & ~flush & rd_wen_dec;

  // EX/MEM boundary: control state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_v       <= '0;
      bubble_ins  <= 1'b0;
      stall_run   <= '0;
      stall_total <= '0;
      err         <= 1'b0;
    end else begin
      if (!hold) begin
        trk_v[0] <= wr0;
        for (int i = 1; i < MEM_STAGES; i++) begin
          trk_v[i] <= trk_v[i-1];
        end
        bubble_ins <= stall | (dec_valid & flush);
        stall_run  <= stall ? sat_inc_run(stall_run) : '0;
      end
      if (clr_cnt) begin
        stall_total <= '0;
      end else if (stall && !hold) begin
        stall_total <= sat_inc_cnt(stall_total);
      end
      err <= err | (stall_run == RUN_W'(MAX_STALL));
    end
  end

  // EX/MEM boundary: tracked destination and load flag travel with trk_v.
  always_ff @(posedge clk) begin
    if (!hold) begin
      trk_rd[0] <= wr0 ? rd_dec : '0;
      trk_ld[0] <= wr0 & is_load_dec;
      for (int i = 1; i < MEM_STAGES; i++) begin
        trk_rd[i] <= trk_rd[i-1];
        trk_ld[i] <= trk_ld[i-1];
      end
    end
  end

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
module tb_load_use_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset, dec_valid, rs1_used, rs2_used, rd_wen_dec, is_load_dec;
  logic       flush, hold, clr_cnt;
  logic [4:0] rs1_dec, rs2_dec, rd_dec;

  logic        d_stall, d_bubble, d_err;
  logic [2:0]  d_run;
  logic [15:0] d_total;
  logic        n_stall, n_bubble, n_err;
  logic [2:0]  n_run;
  logic [15:0] n_total;
  logic        p_stall, p_bubble, p_err;
  logic [2:0]  p_run;
  logic [15:0] p_total;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Default build: MEM_STAGES=2, forwarding on.
  load_use_hazard_ctrl u_dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_dec(rd_dec), .rd_wen_dec(rd_wen_dec), .is_load_dec(is_load_dec),
    .flush(flush), .hold(hold), .clr_cnt(clr_cnt),
    .stall(d_stall), .bubble_ins(d_bubble), .stall_run(d_run),
    .stall_total(d_total), .err(d_err)
  );

  // No-forwarding build.
  load_use_hazard_ctrl #(.FWD_EN(0)) u_nf (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_dec(rd_dec), .rd_wen_dec(rd_wen_dec), .is_load_dec(is_load_dec),
    .flush(flush), .hold(hold), .clr_cnt(clr_cnt),
    .stall(n_stall), .bubble_ins(n_bubble), .stall_run(n_run),
    .stall_total(n_total), .err(n_err)
  );

  // Deep build: 8 tracked stages, so a load-use stall outlasts MAX_STALL.
  load_use_hazard_ctrl #(.MEM_STAGES(8)) u_deep (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_dec(rd_dec), .rd_wen_dec(rd_wen_dec), .is_load_dec(is_load_dec),
    .flush(flush), .hold(hold), .clr_cnt(clr_cnt),
    .stall(p_stall), .bubble_ins(p_bubble), .stall_run(p_run),
    .stall_total(p_total), .err(p_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid   = 1'b0;
    rd_dec      = 5'd0;
    rd_wen_dec  = 1'b0;
    is_load_dec = 1'b0;
    rs1_dec     = 5'd0;
    rs2_dec     = 5'd0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
  endtask

  task automatic instr(input int rd, input int wen, input int ld,
                       input int r1, input int u1, input int r2, input int u2);
    dec_valid   = 1'b1;
    rd_dec      = 5'(rd);
    rd_wen_dec  = (wen != 0);
    is_load_dec = (ld != 0);
    rs1_dec     = 5'(r1);
    rs1_used    = (u1 != 0);
    rs2_dec     = 5'(r2);
    rs2_used    = (u2 != 0);
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0; clr_cnt = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_stall", 32'(d_stall), 0);
    chk("rst_bubble", 32'(d_bubble), 0);
    chk("rst_run", 32'(d_run), 0);
    chk("rst_total", 32'(d_total), 0);
    chk("rst_err", 32'(d_err), 0);
    reset = 1'b0;

    // Load x5 then immediate reader: two stall cycles.
    instr(5, 1, 1, 0, 0, 0, 0); #1;
    chk("t1_load_nostall", 32'(d_stall), 0);
    tick();
    instr(6, 1, 0, 5, 1, 0, 0); #1;
    chk("t1_stall_a", 32'(d_stall), 1);
    chk("t1_run_a", 32'(d_run), 0);
    tick();
    chk("t1_stall_b", 32'(d_stall), 1);
    chk("t1_run_b", 32'(d_run), 1);
    chk("t1_bub_b", 32'(d_bubble), 1);
    chk("t1_tot_b", 32'(d_total), 1);
    tick();
    chk("t1_stall_c", 32'(d_stall), 0);
    chk("t1_run_c", 32'(d_run), 2);
    chk("t1_bub_c", 32'(d_bubble), 1);
    chk("t1_tot_c", 32'(d_total), 2);
    tick();
    idle(); #1;
    chk("t1_run_d", 32'(d_run), 0);
    chk("t1_bub_d", 32'(d_bubble), 0);
    chk("t1_tot_d", 32'(d_total), 2);
    drain();

    // Reader one slot behind: one stall; two slots behind: none.
    instr(5, 1, 1, 0, 0, 0, 0); tick();
    instr(8, 1, 0, 1, 1, 2, 1); #1;
    chk("t2_indep", 32'(d_stall), 0);
    tick();
    instr(9, 1, 0, 0, 0, 5, 1); #1;
    chk("t2_stall_a", 32'(d_stall), 1);
    tick();
    chk("t2_stall_b", 32'(d_stall), 0);
    chk("t2_run_b", 32'(d_run), 1);
    chk("t2_bub_b", 32'(d_bubble), 1);
    tick();
    idle(); #1;
    chk("t2_run_c", 32'(d_run), 0);
    chk("t2_bub_c", 32'(d_bubble), 0);
    instr(5, 1, 1, 0, 0, 0, 0); tick();
    instr(8, 1, 0, 1, 1, 2, 1); tick();
    instr(10, 1, 0, 0, 0, 0, 0); tick();
    instr(9, 1, 0, 0, 0, 5, 1); #1;
    chk("t2_two_behind", 32'(d_stall), 0);
    tick();
    drain();

    // x0 destination and unused rs2 never stall.
    instr(0, 1, 1, 0, 0, 0, 0); tick();
    instr(0, 0, 0, 0, 1, 0, 1); #1;
    chk("t3_x0_d", 32'(d_stall), 0);
    chk("t3_x0_n", 32'(n_stall), 0);
    tick();
    instr(7, 1, 1, 0, 0, 0, 0); tick();
    instr(0, 0, 0, 3, 1, 7, 0); #1;
    chk("t3_unused_d", 32'(d_stall), 0);
    chk("t3_unused_n", 32'(n_stall), 0);
    tick();
    drain();

    // ALU producer: stalls twice without forwarding, never with it.
    instr(3, 1, 0, 0, 0, 0, 0); tick();
    instr(11, 1, 0, 3, 1, 0, 0); #1;
    chk("t4_fwd_a", 32'(d_stall), 0);
    chk("t4_nofwd_a", 32'(n_stall), 1);
    tick();
    chk("t4_fwd_b", 32'(d_stall), 0);
    chk("t4_nofwd_b", 32'(n_stall), 1);
    tick();
    chk("t4_nofwd_c", 32'(n_stall), 0);
    chk("t4_nofwd_run", 32'(n_run), 2);
    chk("t4_nofwd_bub", 32'(n_bubble), 1);
    tick();
    drain();

    chk("tot_accum", 32'(d_total), 3);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    chk("tot_clr", 32'(d_total), 0);

    // Hold for three edges in the middle of a load-use stall.
    instr(5, 1, 1, 0, 0, 0, 0); tick();
    instr(6, 1, 0, 5, 1, 0, 0); #1;
    chk("t5_stall_a", 32'(d_stall), 1);
    tick();
    hold = 1'b1; #1;
    chk("t5_hold_stall", 32'(d_stall), 1);
    tick();
    chk("t5_hold1_stall", 32'(d_stall), 1);
    chk("t5_hold1_run", 32'(d_run), 1);
    chk("t5_hold1_tot", 32'(d_total), 1);
    tick();
    tick();
    hold = 1'b0; #1;
    chk("t5_hold3_stall", 32'(d_stall), 1);
    chk("t5_hold3_run", 32'(d_run), 1);
    chk("t5_hold3_tot", 32'(d_total), 1);
    chk("t5_hold3_bub", 32'(d_bubble), 1);
    tick();
    chk("t5_after_stall", 32'(d_stall), 0);
    chk("t5_after_run", 32'(d_run), 2);
    chk("t5_after_tot", 32'(d_total), 2);
    tick();
    idle(); #1;
    chk("t5_end_run", 32'(d_run), 0);
    chk("t5_end_bub", 32'(d_bubble), 0);
    drain();

    // Flush beats a hazard but still inserts a bubble.
    instr(9, 1, 1, 0, 0, 0, 0); tick();
    instr(12, 1, 0, 9, 1, 0, 0); flush = 1'b1; #1;
    chk("t5_flush_stall", 32'(d_stall), 0);
    tick();
    flush = 1'b0; idle(); #1;
    chk("t5_flush_bub", 32'(d_bubble), 1);
    chk("t5_flush_tot", 32'(d_total), 2);
    drain();

    // clr_cnt wins over a simultaneous increment.
    instr(5, 1, 1, 0, 0, 0, 0); tick();
    instr(6, 1, 0, 5, 1, 0, 0); clr_cnt = 1'b1; #1;
    chk("clr_stall", 32'(d_stall), 1);
    tick();
    clr_cnt = 1'b0; #1;
    chk("clr_win_tot", 32'(d_total), 0);
    chk("clr_win_stall", 32'(d_stall), 1);
    tick();
    chk("clr_next_tot", 32'(d_total), 1);
    chk("clr_next_stall", 32'(d_stall), 0);
    tick();
    drain();

    // Reset in the middle of a stall drops the tracked load.
    instr(5, 1, 1, 0, 0, 0, 0); tick();
    instr(6, 1, 0, 5, 1, 0, 0); #1;
    chk("t6_stall", 32'(d_stall), 1);
    tick();
    reset = 1'b1; #1;
    chk("t6_rst_gate", 32'(d_stall), 0);
    tick();
    reset = 1'b0; #1;
    chk("t6_post_stall", 32'(d_stall), 0);
    chk("t6_post_run", 32'(d_run), 0);
    chk("t6_post_tot", 32'(d_total), 0);
    chk("t6_post_bub", 32'(d_bubble), 0);
    tick();
    drain();

    // Deep build: self-dependent load stream, 8 stalls per 9 cycles.
    reset = 1'b1; idle(); tick(); reset = 1'b0;
    instr(5, 1, 1, 5, 1, 0, 0);
    for (int c = 0; c <= 73740; c++) begin
      #1;
      if (c == 0)     chk("deep_first", 32'(p_stall), 0);
      if (c == 1)     chk("deep_stall", 32'(p_stall), 1);
      if (c == 4) begin
        chk("deep_run3", 32'(p_run), 3);
        chk("deep_err_pre", 32'(p_err), 0);
      end
      if (c == 6)     chk("deep_err_set", 32'(p_err), 1);
      if (c == 9) begin
        chk("deep_accept", 32'(p_stall), 0);
        chk("deep_run_sat", 32'(p_run), 7);
        chk("deep_tot9", 32'(p_total), 8);
      end
      if (c == 73719) chk("deep_tot_pre", 32'(p_total), 65528);
      if (c == 73737) begin
        chk("deep_tot_sat", 32'(p_total), 32'hFFFF);
        chk("deep_run_end", 32'(p_run), 7);
      end
      if (c == 73740) begin
        chk("deep_tot_stay", 32'(p_total), 32'hFFFF);
        chk("deep_err_sticky", 32'(p_err), 1);
        chk("dflt_err_never", 32'(d_err), 0);
      end
      tick();
    end
    reset = 1'b1; idle(); tick(); reset = 1'b0; #1;
    chk("deep_err_rst", 32'(p_err), 0);
    chk("deep_tot_rst", 32'(p_total), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
